// File: rtl/mem_dump_tx.sv
// Memory-to-serial dumper: on start, reads len_words 32-bit words from base_addr
// and sends each one as four little-endian 8N1 UART frames on r_txd.
module mem_dump_tx #(
  parameter int MEM_SIZE    = 4096,
  parameter int SERIAL_WCNT = 868,
  localparam int AW         = $clog2(MEM_SIZE) - 2
) (
  input  logic          w_clk,
  input  logic          r_rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   len_words,
  output logic          busy,
  output logic          done,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic          r_txd
);

  localparam int CW = (SERIAL_WCNT > 1) ? $clog2(SERIAL_WCNT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(SERIAL_WCNT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, TX, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] mem_addr_q;
  logic [15:0]   rem_q;
  logic [23:0]   word_q;
  logic [8:0]    shift_q;
  logic [1:0]    byte_idx_q;
  logic [3:0]    bit_cnt_q;
  logic [CW-1:0] cyc_cnt_q;
  logic          txd_q;
  logic          bit_end;
  logic          word_end;

  // Request/response: start is a one-cycle request honoured only in IDLE (never
  // queued); done is a one-cycle response, and busy covers FETCH..TX in between.
  assign bit_end  = (cyc_cnt_q == CMAX);
  assign word_end = (state_q == TX) && bit_end && (bit_cnt_q == 4'd9) && (byte_idx_q == 2'd3);

  assign busy     = (state_q == FETCH) || (state_q == LATCH) || (state_q == TX);
  assign done     = (state_q == DONE);
  assign mem_en   = (state_q == FETCH);
  assign mem_addr = mem_addr_q;
  assign r_txd    = txd_q;

  always_ff @(posedge w_clk) begin
    if (r_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len_words == 16'd0) ? DONE : FETCH;
      FETCH:   state_d = LATCH;
      LATCH:   state_d = TX;
      TX:      if (word_end) state_d = (rem_q == 16'd1) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (r_rst) begin
      addr_q     <= '0;
      mem_addr_q <= '0;
      rem_q      <= '0;
      word_q     <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      bit_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (start) begin
            addr_q <= base_addr;
            rem_q  <= len_words;
            if (len_words != 16'd0) mem_addr_q <= base_addr;
          end
        end
        LATCH: begin
          // Byte 0 goes straight into the shifter; bytes 1..3 wait in word_q.
          word_q     <= mem_rdata[31:8];
          shift_q    <= {1'b1, mem_rdata[7:0]};
          byte_idx_q <= '0;
          bit_cnt_q  <= '0;
          cyc_cnt_q  <= '0;
          txd_q      <= 1'b0;
        end
        TX: begin
          if (!bit_end) begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
          end else begin
            cyc_cnt_q <= '0;
            if (bit_cnt_q != 4'd9) begin
              txd_q     <= shift_q[0];
              shift_q   <= {1'b0, shift_q[8:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (byte_idx_q != 2'd3) begin
              // Next start bit follows the stop bit with no gap.
              byte_idx_q <= byte_idx_q + 2'd1;
              bit_cnt_q  <= '0;
              txd_q      <= 1'b0;
              shift_q    <= {1'b1, word_q[7:0]};
              word_q     <= {8'h00, word_q[23:8]};
            end else begin
              txd_q  <= 1'b1;
              addr_q <= addr_q + 1'b1;
              rem_q  <= rem_q - 16'd1;
              if (rem_q != 16'd1) mem_addr_q <= addr_q + 1'b1;
            end
          end
        end
        default: txd_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx: table of single-word vectors plus hand-written
// sequences for wrap, zero length, ignored starts and reset mid-frame.
module tb_mem_dump_tx;
  localparam int WCNT = 4;
  localparam int MSZ  = 64;
  localparam int MAXC = 1024;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  base_addr;
  logic [15:0] len_words;
  logic        busy;
  logic        done;
  logic        mem_en;
  logic [3:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        txd;

  logic [31:0] mem [16];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  int checks = 0;
  int failures = 0;

  logic       txd_log  [MAXC];
  logic       en_log   [MAXC];
  logic       busy_log [MAXC];
  logic [3:0] addr_log [MAXC];
  int done_cyc;
  int done_cnt;

  typedef struct {
    logic [3:0]  base;
    logic [31:0] word;
    logic [31:0] seq;
    int          exp_done;
  } vec_t;
  vec_t vecs[4];

  mem_dump_tx #(.MEM_SIZE(MSZ), .SERIAL_WCNT(WCNT)) dut (
    .w_clk(clk),
    .r_rst(rst),
    .start(start),
    .base_addr(base_addr),
    .len_words(len_words),
    .busy(busy),
    .done(done),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .r_txd(txd)
  );

  // clock / RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART decoder, samples mid-bit
  int   mon_cnt = 0;
  bit   mon_active = 0;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active = 1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
    end
    if (mon_active && (mon_cnt % WCNT) == WCNT / 2) begin
      if (mon_cnt / WCNT == 0) begin
        check("start_bit", 32'(txd), 32'd0);
      end else if (mon_cnt / WCNT <= 8) begin
        mon_byte[mon_cnt / WCNT - 1] = txd;
      end else begin
        check("stop_bit", 32'(txd), 32'd1);
        got_q.push_back(mon_byte);
        mon_active = 0;
      end
    end
  end

  task automatic push32(input logic [31:0] seq);
    for (int i = 0; i < 4; i++) exp_q.push_back(seq[31 - 8 * i -: 8]);
  endtask

  task automatic compare_bytes(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({name, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  // Start a request; logs cycles 1.. until done (cycle 1 = cycle after start edge).
  task automatic run_xfer(input logic [3:0] b, input logic [15:0] l, input bit extra);
    @(negedge clk);
    start = 1'b1; base_addr = b; len_words = l;
    @(negedge clk);
    start = 1'b0;
    done_cyc = -1;
    done_cnt = 0;
    for (int c = 1; c < MAXC; c++) begin
      txd_log[c] = txd; en_log[c] = mem_en; addr_log[c] = mem_addr; busy_log[c] = busy;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      start = extra && ((c % 50) == 10 || c == 163 || c == 164 || done);
      if (start) begin
        base_addr = 4'd9;
        len_words = 16'd5;
      end
      if (done) break;
      @(negedge clk);
    end
  endtask

  function automatic int busy_count(input int last);
    int n = 0;
    for (int c = 1; c <= last; c++) n += int'(busy_log[c]);
    return n;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{4'd5,  32'h44332211, 32'h11223344, 163};
    vecs[1] = '{4'd0,  32'hDEADBEEF, 32'hEFBEADDE, 163};
    vecs[2] = '{4'd15, 32'h00FF00FF, 32'hFF00FF00, 163};
    vecs[3] = '{4'd9,  32'h80000001, 32'h01000080, 163};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b1; start = 1'b0; base_addr = '0; len_words = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {28'd0, txd, busy, done, mem_en}, 32'h8);
    check("reset_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;

    // quiet after reset
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({txd, busy, done, mem_en} !== 4'b1000) n++;
    end
    check("idle_50_bad_cycles", 32'(n), 32'd0);

    // single-word vectors
    for (int v = 0; v < 4; v++) begin
      mem[vecs[v].base] = vecs[v].word;
      push32(vecs[v].seq);
      run_xfer(vecs[v].base, 16'd1, 1'b0);
      check("v_done_cyc", 32'(done_cyc), 32'(vecs[v].exp_done));
      check("v_c1_en_busy", {30'd0, en_log[1], busy_log[1]}, 32'h3);
      check("v_c1_addr", 32'(addr_log[1]), 32'(vecs[v].base));
      check("v_c2_en_txd", {30'd0, en_log[2], txd_log[2]}, 32'h1);
      check("v_c3_txd", 32'(txd_log[3]), 32'd0);
      check("v_busy_cycles", 32'(busy_count(163)), 32'd162);
      check("v_done_busy", 32'(busy_log[163]), 32'd0);
      compare_bytes("v");
    end

    // wrap: base 15, len 2
    mem[15] = 32'hA0A1A2A3;
    mem[0]  = 32'hB0B1B2B3;
    push32(32'hA3A2A1A0);
    push32(32'hB3B2B1B0);
    run_xfer(4'd15, 16'd2, 1'b0);
    check("wrap_done_cyc", 32'(done_cyc), 32'd325);
    check("wrap_addr1", 32'(addr_log[1]), 32'd15);
    check("wrap_addr2_en", {27'd0, en_log[163], addr_log[163]}, 32'h10);
    check("wrap_gap_txd", {28'd0, txd_log[162], txd_log[163], txd_log[164], txd_log[165]}, 32'hE);
    check("wrap_gap_en164", 32'(en_log[164]), 32'd0);
    check("wrap_busy_cycles", 32'(busy_count(325)), 32'd324);
    compare_bytes("wrap");

    // zero length
    run_xfer(4'd2, 16'd0, 1'b0);
    check("len0_done_cyc", 32'(done_cyc), 32'd1);
    check("len0_outs", {29'd0, busy_log[1], en_log[1], txd_log[1]}, 32'h1);
    @(negedge clk);
    check("len0_done_once", {30'd0, done, busy}, 32'h0);
    compare_bytes("len0");

    // ignored starts during base=0 len=3, then start right after done
    mem[0] = 32'hB0B1B2B3;
    mem[1] = 32'hC0C1C2C3;
    mem[2] = 32'hD0D1D2D3;
    push32(32'hB3B2B1B0);
    push32(32'hC3C2C1C0);
    push32(32'hD3D2D1D0);
    run_xfer(4'd0, 16'd3, 1'b1);
    check("extra_done_cyc", 32'(done_cyc), 32'd487);
    check("extra_done_cnt", 32'(done_cnt), 32'd1);
    check("extra_addr3", 32'(addr_log[325]), 32'd2);
    compare_bytes("extra");
    mem[4] = 32'h5A6B7C8D;
    push32(32'h8D7C6B5A);
    run_xfer(4'd4, 16'd1, 1'b0);
    check("back2back_done_cyc", 32'(done_cyc), 32'd163);
    check("back2back_addr", 32'(addr_log[1]), 32'd4);
    compare_bytes("back2back");

    // reset during data bit 0 of byte 2
    mem[3] = 32'h12005634;
    @(negedge clk);
    start = 1'b1; base_addr = 4'd3; len_words = 16'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (87) @(negedge clk);
    check("rst_pre_txd", {31'd0, txd}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outs", {28'd0, txd, busy, done, mem_en}, 32'h8);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || txd !== 1'b1) n++;
    end
    check("rst_quiet_bad_cycles", 32'(n), 32'd0);
    exp_q.delete();
    got_q.delete();
    mem[7] = 32'h0F1E2D3C;
    push32(32'h3C2D1E0F);
    run_xfer(4'd7, 16'd1, 1'b0);
    check("post_rst_done_cyc", 32'(done_cyc), 32'd163);
    check("post_rst_addr", 32'(addr_log[1]), 32'd7);
    compare_bytes("post_rst");

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
